// File: rtl/uart_tx_engine_if.sv
// Host-side handshake and serial outputs of the UART transmitter.
// The host drives tx_start/d_in; the engine returns the line and status flags.
interface uart_tx_engine_if #(
  parameter int D_BIT = 8
);
  logic             tx_start;
  logic [D_BIT-1:0] d_in;
  logic             tx_ready;
  logic             tx;
  logic             tx_busy;
  logic             tx_done;

  modport master (output tx_start, d_in, input tx_ready, tx, tx_busy, tx_done);
  modport slave  (input tx_start, d_in, output tx_ready, tx, tx_busy, tx_done);
endinterface

// File: rtl/uart_tx_engine.sv
// 8N1 UART transmitter paced by a 16x oversample tick, with a one-deep
// holding register so consecutive frames leave the line with no idle gap.
module uart_tx_engine #(
  parameter int D_BIT   = 8,
  parameter int SB_TICK = 16,
  parameter int OS_TICK = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            s_tick,
  uart_tx_engine_if.slave bus
);

  localparam int S_MAX = (SB_TICK > OS_TICK) ? SB_TICK : OS_TICK;
  localparam int S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
  localparam int N_W   = (D_BIT > 1) ? $clog2(D_BIT) : 1;

  localparam logic [S_W-1:0] OS_LAST = S_W'(OS_TICK - 1);
  localparam logic [S_W-1:0] SB_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST  = N_W'(D_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_next;
  logic [S_W-1:0]   s, s_next;
  logic [N_W-1:0]   n, n_next;
  logic [D_BIT-1:0] shift, shift_next;
  logic [D_BIT-1:0] hold;
  logic             hold_valid;
  logic             load;
  logic             tx_reg, tx_next;
  logic             done_reg, done_next;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    shift_next = shift;
    load       = 1'b0;
    done_next  = 1'b0;

    if (s_tick) begin
      case (state)
        IDLE: begin
          if (hold_valid) begin
            load       = 1'b1;
            s_next     = '0;
            state_next = START;
          end
        end
        START: begin
          if (s == OS_LAST) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s + 1'b1;
          end
        end
        DATA: begin
          if (s == OS_LAST) begin
            s_next     = '0;
            shift_next = shift >> 1;
            if (n == N_LAST) state_next = STOP;
            else             n_next     = n + 1'b1;
          end else begin
            s_next = s + 1'b1;
          end
        end
        STOP: begin
          if (s == SB_LAST) begin
            done_next = 1'b1;
            s_next    = '0;
            // A queued byte starts its frame on the very edge the stop bit ends.
            if (hold_valid) begin
              load       = 1'b1;
              state_next = START;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    if (load) shift_next = hold;

    // The line level is derived from the next state so tx is a clean register.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      s        <= '0;
      n        <= '0;
      shift    <= '0;
      tx_reg   <= 1'b1;
      done_reg <= 1'b0;
    end else begin
      state    <= state_next;
      s        <= s_next;
      n        <= n_next;
      shift    <= shift_next;
      tx_reg   <= tx_next;
      done_reg <= done_next;
    end
  end

  // NOTE: the holding register is cleared on reset so a byte queued before
  // reset can never leak out afterwards.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold       <= '0;
      hold_valid <= 1'b0;
    end else if (bus.tx_start && !hold_valid) begin
      hold       <= bus.d_in;
      hold_valid <= 1'b1;
    end else if (load) begin
      hold_valid <= 1'b0;
    end
  end

  assign bus.tx       = tx_reg;
  assign bus.tx_ready = !hold_valid;
  assign bus.tx_busy  = (state != IDLE);
  assign bus.tx_done  = done_reg;

endmodule
